// File: rtl/sram_controller.sv
// Avalon-MM slave driving one 16-bit asynchronous SRAM with fixed-length, registered-strobe bus cycles.
// Optional: define SRAM_CTRL_DQ_INPUT_REG_EN to pass sram_dq through an input flop before readdata.
module sram_controller #(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            byteenable,
  input  logic                  read,
  output logic [15:0]           readdata,
  output logic                  readdataready,
  input  logic                  write,
  input  logic [15:0]           writedata,
  output logic                  waitrequest,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [15:0]           sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

`ifdef SRAM_CTRL_DQ_INPUT_REG_EN
  localparam int RD_LAST = READ_WAIT;
`else
  localparam int RD_LAST = READ_WAIT - 1;
`endif
  localparam int CNT_MAX = (RD_LAST > WRITE_WAIT - 1) ? RD_LAST : WRITE_WAIT - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_accept;
  logic                  w_capture;
  logic [1:0]            w_be_nxt;
  logic [1:0]            r_be;
  logic [15:0]           r_wdata;
  logic [15:0]           r_rdata;
  logic [15:0]           w_rd_src;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rdy;
  logic                  r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_dq_oe;
  logic                  w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n, w_dq_oe;

`ifdef SRAM_CTRL_DQ_INPUT_REG_EN
  logic [15:0] r_dq_in;
  always_ff @(posedge clock) r_dq_in <= sram_dq;
  assign w_rd_src = r_dq_in;
`else
  assign w_rd_src = sram_dq;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (write) begin
          w_state_nxt = WR_SETUP;
          w_accept    = 1'b1;
        end else if (read) begin
          w_state_nxt = RD;
          w_accept    = 1'b1;
        end
      end
      RD: begin
        if (r_cnt == CNT_W'(RD_LAST)) begin
          w_state_nxt = IDLE;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      WR_SETUP: begin
        w_state_nxt = WR_PULSE;
        w_cnt_nxt   = '0;
      end
      WR_PULSE: begin
        if (r_cnt == CNT_W'(WRITE_WAIT - 1)) w_state_nxt = WR_HOLD;
        else                                  w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      WR_HOLD: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they can be registered glitch-free
  assign w_be_nxt = w_accept ? byteenable : r_be;

  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_ub_n  = 1'b1;
    w_lb_n  = 1'b1;
    w_dq_oe = 1'b0;
    case (w_state_nxt)
      RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        w_ce_n  = 1'b0;
        w_ub_n  = ~w_be_nxt[1];
        w_lb_n  = ~w_be_nxt[0];
        w_dq_oe = 1'b1;
        w_we_n  = !(w_state_nxt == WR_PULSE && w_be_nxt != 2'b00);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      r_rdy   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_ub_n  <= w_ub_n;
      r_lb_n  <= w_lb_n;
      r_dq_oe <= w_dq_oe;
      r_rdy   <= w_capture;
      if (w_capture) r_rdata <= w_rd_src;
      if (w_accept)  r_addr  <= address;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_wdata <= writedata;
      r_be    <= byteenable;
    end
  end

  assign waitrequest   = reset | (r_state != IDLE);
  assign readdata      = r_rdata;
  assign readdataready = r_rdy;
  assign sram_addr     = r_addr;
  assign sram_ce_n     = r_ce_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_we_n     = r_we_n;
  assign sram_ub_n     = r_ub_n;
  assign sram_lb_n     = r_lb_n;
  assign sram_dq       = r_dq_oe ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: SRAM pin model plus a word-level reference memory.
module tb_sram_controller;
  localparam int AW = 20;
  localparam int RW = 2;
  localparam int WW = 2;
`ifdef SRAM_CTRL_DQ_INPUT_REG_EN
  localparam int RD_LAT = RW + 2;
`else
  localparam int RD_LAT = RW + 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [1:0]    byteenable = 2'b00;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [15:0]   writedata = '0;
  logic [15:0]   readdata;
  logic          readdataready;
  logic          waitrequest;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  int checks = 0;
  int errors = 0;

  sram_controller #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clock(clock), .reset(reset), .address(address), .byteenable(byteenable),
    .read(read), .readdata(readdata), .readdataready(readdataready),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM pin model
  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
  always @(posedge clock) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk(tag, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be,
                    input logic with_rd);
    int busy, we_lo;
    logic dq_ok, pin_ok, rdy_seen, first_we, last_we;
    logic [15:0] old;
    chk("wr_issue_wait", 32'(waitrequest), 32'd0);
    address = a; writedata = d; byteenable = be; write = 1'b1; read = with_rd;
    @(negedge clock);
    write = 1'b0; read = 1'b0;
    busy = 0; we_lo = 0; dq_ok = 1'b1; pin_ok = 1'b1; rdy_seen = 1'b0;
    first_we = sram_we_n; last_we = 1'b0;
    while (waitrequest && busy < 20) begin
      busy++;
      if (!sram_we_n) we_lo++;
      if (sram_dq !== d) dq_ok = 1'b0;
      if ({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n} !== {1'b0, 1'b1, ~be} || sram_addr !== a)
        pin_ok = 1'b0;
      if (readdataready) rdy_seen = 1'b1;
      last_we = sram_we_n;
      @(negedge clock);
    end
    chk("wr_busy_cycles", 32'(busy), 32'(WW + 2));
    chk("wr_we_low_cycles", 32'(we_lo), (be == 2'b00) ? 32'd0 : 32'(WW));
    chk("wr_setup_we_high", 32'(first_we), 32'd1);
    chk("wr_hold_we_high", 32'(last_we), 32'd1);
    chk("wr_dq_driven", 32'(dq_ok), 32'd1);
    chk("wr_pins", 32'(pin_ok), 32'd1);
    chk("wr_no_rdy", 32'(rdy_seen), 32'd0);
    chk_idle_pins("wr_end_idle_pins");
    old = ref_mem[a[7:0]];
    ref_mem[a[7:0]] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endtask

  task automatic rd(input logic [AW-1:0] a);
    int lat;
    logic pin_ok;
    chk("rd_issue_wait", 32'(waitrequest), 32'd0);
    address = a; read = 1'b1; byteenable = 2'($urandom_range(0, 3));
    @(negedge clock);
    read = 1'b0; lat = 1; pin_ok = 1'b1;
    while (!readdataready && lat < 20) begin
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b00100 || sram_addr !== a)
        pin_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    chk("rd_latency", 32'(lat), 32'(RD_LAT));
    chk("rd_pins", 32'(pin_ok), 32'd1);
    chk("rd_data", 32'(readdata), 32'(ref_mem[a[7:0]]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_waitrequest", 32'(waitrequest), 32'd1);
      chk_idle_pins("rst_pins");
      chk("rst_rdy", 32'(readdataready), 32'd0);
      chk("rst_readdata", 32'(readdata), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_waitrequest", 32'(waitrequest), 32'd0);
    chk_idle_pins("post_rst_pins");

    wr(20'h00010, 16'hA55A, 2'b11, 1'b0);
    rd(20'h00010);
    chk("wr_rd_a55a", 32'(readdata), 32'h0000A55A);
    @(negedge clock);
    chk("rdy_one_cycle", 32'(readdataready), 32'd0);
    chk("readdata_hold", 32'(readdata), 32'h0000A55A);

    wr(20'h00010, 16'h1234, 2'b01, 1'b0);
    rd(20'h00010);
    chk("byte_write_a534", 32'(readdata), 32'h0000A534);

    wr(20'h00010, 16'hFFFF, 2'b00, 1'b0);
    rd(20'h00010);
    chk("zero_be_unchanged", 32'(readdata), 32'h0000A534);

    rd(20'h00000);
    chk("b2b_rdy_and_ready", 32'({readdataready, waitrequest}), 32'b10);
    rd(20'h00001);

    wr(20'h00020, 16'h5A5A, 2'b11, 1'b1);
    rd(20'h00020);
    chk("priority_write", 32'(readdata), 32'h00005A5A);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        wr(20'($urandom_range(0, 63)), 16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
      else
        rd(20'($urandom_range(0, 63)));
    end

    // Reset arriving during the write pulse
    @(negedge clock);
    address = 20'h000F0; writedata = 16'hBEEF; byteenable = 2'b11; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
    @(negedge clock);
    chk("abort_in_pulse", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk_idle_pins("abort_pins");
    chk("abort_waitrequest", 32'(waitrequest), 32'd1);
    chk("abort_rdy", 32'(readdataready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk_idle_pins("abort_quiet_pins");
      chk("abort_quiet_bus", 32'({readdataready, waitrequest}), 32'd0);
    end
    rd(20'h00030);
    rd(20'h00010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Avalon-MM slave that serves one 16-bit asynchronous SRAM (IS61WV102416-class) on the board pins. It sits at the far end of the Avalon-MM path from the SRAM bridge: the bridge's master port connects here. Each accepted read or write becomes a fixed-length, parameterised SRAM bus cycle driven by a small state machine. The block returns read data with a single-cycle `readdataready` pulse.

## Interface
- `ADDR_WIDTH`, 20: word address width, Avalon and SRAM.
- `READ_WAIT`, 2: cycles `oe_n`/`ce_n` are held low before data capture; minimum 1.
- `WRITE_WAIT`, 2: cycles `we_n` is held low; minimum 1.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `address` in ADDR_WIDTH: word address.
- `byteenable` in 2: bit1 = upper byte, bit0 = lower byte.
- `read` in 1: read request.
- `readdata` out 16: read data, valid while `readdataready`=1.
- `readdataready` out 1: one-cycle read-data strobe.
- `write` in 1: write request.
- `writedata` in 16: write data.
- `waitrequest` out 1: 1 = command not accepted this cycle.
- `sram_addr` out ADDR_WIDTH: SRAM address.
- `sram_dq` inout 16: SRAM data, tri-stated unless writing.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM strobes.

## Operation
- **States:** IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- **IDLE:**
  - `waitrequest`=0.
  - `read` or `write` high at a rising edge is an accept. `address`, `byteenable` and `writedata` are latched.
  - `write` wins if both are high; the read is dropped.
- **RD:**
  - `ce_n`=0, `oe_n`=0, `ub_n`=`lb_n`=0 (full word always read). `dq` is tri-stated.
  - A counter runs READ_WAIT cycles.
  - On the edge ending the last RD cycle: `sram_dq` is registered into `readdata`, `readdataready` is set for one cycle, and the state returns to IDLE.
- **WR_SETUP (1 cycle):**
  - `ce_n`=0, `we_n`=1.
  - `dq` is driven with the latched data.
  - `ub_n`/`lb_n` = inverted latched `byteenable`.
- **WR_PULSE (WRITE_WAIT cycles):** same outputs as WR_SETUP, with `we_n`=0.
  - Exception: latched `byteenable`=2'b00 keeps `we_n`=1; the cycle still runs full length.
- **WR_HOLD (1 cycle):** `we_n`=1, `dq` still driven, `ce_n`=0. Then IDLE.
- **Outside IDLE:** `waitrequest`=1. Avalon inputs are ignored and the master holds them.
- `sram_addr` is taken from the latched address in every non-IDLE state and holds its last value in IDLE.
- `readdata` holds its last captured value until the next capture.

## Timing
- **Reset values (next edge after `reset`=1):**
  - state IDLE, `waitrequest`=1 while `reset` is high.
  - `readdataready`=0, `readdata`=0, `sram_addr`=0.
  - All SRAM strobes =1.
  - `dq` tri-stated.
- **Reset mid-operation:** the bus cycle is aborted at that edge. No `readdataready` pulse is issued, and the write is not retried.
- **Read:** accept at edge E0 → `readdataready`=1 in the cycle after edge E0+READ_WAIT. That is READ_WAIT+1 cycles from accept; READ_WAIT=2 gives 3.
- **Write occupancy:** WRITE_WAIT+2 cycles.
- **Next command:** accepted at the first edge where the state is IDLE. This includes the cycle in which `readdataready`=1, giving back-to-back reads with no bubble.
- **Strobe glitches:** all SRAM strobes and `dq` output-enable are registered outputs, so they do not glitch.
- **Data/`we_n` ordering:** `dq` is never driven while `oe_n`=0. Data is stable one cycle before `we_n` falls and one cycle after it rises.

## Configuration
- **`SRAM_CTRL_DQ_INPUT_REG_EN`**
  - **Defined:** `sram_dq` is registered in an input flop first, and `readdata` captures that flop one edge later. RD gains one extra cycle, so read latency is READ_WAIT+2. Writes are unchanged.
  - **Undefined:** `sram_dq` is captured directly, as above.

## Test plan
- **Reset:** assert `reset` for 3 cycles → all strobes =1, `dq`=Z, `waitrequest`=1 during reset then 0, `readdataready`=0.
- **Write then read:**
  - Write `address`=0x00010, `writedata`=0xA55A, `byteenable`=2'b11.
  - Expect `we_n` low for exactly 2 cycles, `dq`=0xA55A from WR_SETUP through WR_HOLD, `waitrequest` high 4 cycles.
  - Read 0x00010 → `readdataready` 3 cycles after accept, `readdata`=0xA55A.
- **Byte write:** write 0x00010 with 0x1234 and `byteenable`=2'b01 → `lb_n`=0, `ub_n`=1. Read back → 0xA534.
- **Zero byteenable:** write with `byteenable`=2'b00 → `we_n` stays 1, occupancy still 4 cycles, memory unchanged.
- **Back-to-back and priority:**
  - Two consecutive reads (0x0, 0x1) → the second is accepted in the cycle its predecessor's `readdataready`=1.
  - `read` and `write` high together → only the write is performed.
- **Reset in WR_PULSE:** assert `reset` → `we_n`=1 and `dq`=Z on the next edge, no further SRAM activity. With the macro defined, also re-check read latency is 4.
